// File: rtl/spm_banked.sv
// Word-interleaved, multi-bank scratchpad shared by the IF and MEM stages.
// Same-bank requests are arbitrated (MEM first, IF after STARVE_MAX stalls); reads return one cycle after acceptance.
module spm_banked #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int NUM_BANKS  = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   if_spm_addr,
  input  logic                if_spm_as_,
  input  logic                if_spm_rw,
  input  logic [DATA_W-1:0]   if_spm_wr_data,
  output logic                if_spm_rdy,
  output logic [DATA_W-1:0]   if_spm_rd_data,
  output logic                if_spm_rd_valid,
  input  logic [ADDR_W-1:0]   mem_spm_addr,
  input  logic                mem_spm_as_,
  input  logic                mem_spm_rw,
  input  logic [DATA_W/8-1:0] mem_spm_be,
  input  logic [DATA_W-1:0]   mem_spm_wr_data,
  output logic                mem_spm_rdy,
  output logic [DATA_W-1:0]   mem_spm_rd_data,
  output logic                mem_spm_rd_valid,
  output logic [15:0]         spm_conflict_cnt
);

  localparam int SEL_W  = $clog2(NUM_BANKS);
  localparam int BANK_W = (SEL_W > 0) ? SEL_W : 1;
  localparam int ROW_W  = (ADDR_W - SEL_W > 0) ? (ADDR_W - SEL_W) : 1;
  localparam int DEPTH  = 1 << ROW_W;
  localparam int ST_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int NB     = DATA_W / 8;

  // Handshake: a port requests while its as_ is low; the request is taken
  // on the rising edge of any cycle in which rdy is also high. A stalled
  // requester keeps addr/rw/data/be steady until it sees rdy.

  logic [BANK_W-1:0] w_if_bank, w_mem_bank;
  logic [ROW_W-1:0]  w_if_row, w_mem_row;
  logic              w_if_req, w_mem_req, w_conflict, w_if_wins;
  logic              w_if_acc, w_mem_acc;
  logic [ST_W-1:0]   r_starve_cnt;
  logic [15:0]       r_conflict_cnt;
  logic [DATA_W-1:0] w_bank_q [NUM_BANKS];

  logic              r_if_valid, r_mem_valid;
  logic [BANK_W-1:0] r_if_bank, r_mem_bank;
  logic [DATA_W-1:0] r_if_hold, r_mem_hold;

  generate
    if (SEL_W > 0) begin : g_sel
      assign w_if_bank  = if_spm_addr[BANK_W-1:0];
      assign w_mem_bank = mem_spm_addr[BANK_W-1:0];
    end else begin : g_nosel
      assign w_if_bank  = '0;
      assign w_mem_bank = '0;
    end
  endgenerate

  assign w_if_row  = ROW_W'(if_spm_addr >> SEL_W);
  assign w_mem_row = ROW_W'(mem_spm_addr >> SEL_W);

  assign w_if_req   = ~if_spm_as_;
  assign w_mem_req  = ~mem_spm_as_;
  assign w_conflict = w_if_req & w_mem_req & (w_if_bank == w_mem_bank);
  assign w_if_wins  = (r_starve_cnt == ST_W'(STARVE_MAX));

  assign if_spm_rdy  = ~(w_conflict & ~w_if_wins);
  assign mem_spm_rdy = ~(w_conflict & w_if_wins);
  assign w_if_acc    = w_if_req & if_spm_rdy;
  assign w_mem_acc   = w_mem_req & mem_spm_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_if_req && !if_spm_rdy) r_starve_cnt <= r_starve_cnt + 1'b1;
      else if (w_if_acc)           r_starve_cnt <= '0;
      if (w_conflict && r_conflict_cnt != 16'hFFFF)
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign spm_conflict_cnt = r_conflict_cnt;

  // Arbitration guarantees at most one accepted port per bank per cycle,
  // so each bank is a true single-port array with its own read register.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    logic              w_mem_hit, w_if_hit;

    assign w_mem_hit = w_mem_acc && (w_mem_bank == BANK_W'(b));
    assign w_if_hit  = w_if_acc && (w_if_bank == BANK_W'(b));

    always_ff @(posedge clk) begin
      if (!reset) begin
        if (w_mem_hit) begin
          if (mem_spm_rw) begin
            r_q <= r_mem[w_mem_row];
          end else begin
            for (int i = 0; i < NB; i++)
              if (mem_spm_be[i]) r_mem[w_mem_row][8*i +: 8] <= mem_spm_wr_data[8*i +: 8];
          end
        end else if (w_if_hit) begin
          if (if_spm_rw) r_q <= r_mem[w_if_row];
          else           r_mem[w_if_row] <= if_spm_wr_data;
        end
      end
    end

    assign w_bank_q[b] = r_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_if_bank   <= '0;
      r_mem_bank  <= '0;
      r_if_hold   <= '0;
      r_mem_hold  <= '0;
    end else begin
      r_if_valid  <= w_if_acc & if_spm_rw;
      r_mem_valid <= w_mem_acc & mem_spm_rw;
      r_if_bank   <= w_if_bank;
      r_mem_bank  <= w_mem_bank;
      if (r_if_valid)  r_if_hold  <= w_bank_q[r_if_bank];
      if (r_mem_valid) r_mem_hold <= w_bank_q[r_mem_bank];
    end
  end

  // Masking with reset drops a read whose data would land in a reset cycle.
  assign if_spm_rd_valid  = r_if_valid & ~reset;
  assign mem_spm_rd_valid = r_mem_valid & ~reset;
  assign if_spm_rd_data   = if_spm_rd_valid  ? w_bank_q[r_if_bank]  : r_if_hold;
  assign mem_spm_rd_data  = mem_spm_rd_valid ? w_bank_q[r_mem_bank] : r_mem_hold;

endmodule

// File: tb/tb_spm_banked.sv
// Directed scoreboard bench for spm_banked: driver pushes expected read data,
// a negedge monitor pops it on each rd_valid and checks held data otherwise.
module tb_spm_banked;

  logic        clk;
  logic        reset;
  logic [11:0] if_spm_addr;
  logic        if_spm_as_;
  logic        if_spm_rw;
  logic [31:0] if_spm_wr_data;
  logic        if_spm_rdy;
  logic [31:0] if_spm_rd_data;
  logic        if_spm_rd_valid;
  logic [11:0] mem_spm_addr;
  logic        mem_spm_as_;
  logic        mem_spm_rw;
  logic [3:0]  mem_spm_be;
  logic [31:0] mem_spm_wr_data;
  logic        mem_spm_rdy;
  logic [31:0] mem_spm_rd_data;
  logic        mem_spm_rd_valid;
  logic [15:0] spm_conflict_cnt;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];
  logic [31:0] last_if, last_mem;
  int          n_vec, n_err;

  spm_banked #(.DATA_W(32), .ADDR_W(12), .NUM_BANKS(2), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_spm_addr(if_spm_addr), .if_spm_as_(if_spm_as_), .if_spm_rw(if_spm_rw),
    .if_spm_wr_data(if_spm_wr_data), .if_spm_rdy(if_spm_rdy),
    .if_spm_rd_data(if_spm_rd_data), .if_spm_rd_valid(if_spm_rd_valid),
    .mem_spm_addr(mem_spm_addr), .mem_spm_as_(mem_spm_as_), .mem_spm_rw(mem_spm_rw),
    .mem_spm_be(mem_spm_be), .mem_spm_wr_data(mem_spm_wr_data), .mem_spm_rdy(mem_spm_rdy),
    .mem_spm_rd_data(mem_spm_rd_data), .mem_spm_rd_valid(mem_spm_rd_valid),
    .spm_conflict_cnt(spm_conflict_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drv_if(input logic req, input logic [11:0] a, input logic rw, input logic [31:0] d);
    if_spm_as_     = ~req;
    if_spm_addr    = a;
    if_spm_rw      = rw;
    if_spm_wr_data = d;
  endtask

  task automatic drv_mem(input logic req, input logic [11:0] a, input logic rw,
                         input logic [3:0] be, input logic [31:0] d);
    mem_spm_as_     = ~req;
    mem_spm_addr    = a;
    mem_spm_rw      = rw;
    mem_spm_be      = be;
    mem_spm_wr_data = d;
  endtask

  // Checks both rdy flags mid-cycle, queues read data expected from accepted
  // reads, then advances to just after the next rising edge.
  task automatic cycle(input logic exp_if_rdy, input logic exp_mem_rdy,
                       input logic [31:0] exp_if_d, input logic [31:0] exp_mem_d);
    @(negedge clk);
    check("if_rdy", {31'b0, if_spm_rdy}, {31'b0, exp_if_rdy});
    check("mem_rdy", {31'b0, mem_spm_rdy}, {31'b0, exp_mem_rdy});
    if (!if_spm_as_ && exp_if_rdy && if_spm_rw)    exp_if_q.push_back(exp_if_d);
    if (!mem_spm_as_ && exp_mem_rdy && mem_spm_rw) exp_mem_q.push_back(exp_mem_d);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      check("if_valid_in_reset", {31'b0, if_spm_rd_valid}, 32'd0);
      check("mem_valid_in_reset", {31'b0, mem_spm_rd_valid}, 32'd0);
      check("if_data_in_reset", if_spm_rd_data, last_if);
      check("mem_data_in_reset", mem_spm_rd_data, last_mem);
      exp_if_q.delete();
      exp_mem_q.delete();
      last_if  = 32'd0;
      last_mem = 32'd0;
    end else begin
      if (if_spm_rd_valid) begin
        if (exp_if_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL if_rd_valid: got unexpected pulse, expected none");
        end else begin
          e = exp_if_q.pop_front();
          check("if_rd_data", if_spm_rd_data, e);
          last_if = e;
        end
      end else begin
        check("if_rd_hold", if_spm_rd_data, last_if);
      end
      if (mem_spm_rd_valid) begin
        if (exp_mem_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mem_rd_valid: got unexpected pulse, expected none");
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_rd_data", mem_spm_rd_data, e);
          last_mem = e;
        end
      end else begin
        check("mem_rd_hold", mem_spm_rd_data, last_mem);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0;
    last_if = 32'd0; last_mem = 32'd0;
    reset = 1'b1;
    drv_if(1'b0, 12'h000, 1'b1, 32'h0);
    drv_mem(1'b0, 12'h000, 1'b1, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_conflict_cnt", {16'b0, spm_conflict_cnt}, 32'd0);
    check("reset_if_valid", {31'b0, if_spm_rd_valid}, 32'd0);
    check("reset_mem_data", mem_spm_rd_data, 32'd0);

    // basic MEM write then read
    drv_mem(1'b1, 12'h004, 1'b0, 4'b1111, 32'hDEADBEEF);
    cycle(1, 1, 32'h0, 32'h0);
    drv_mem(1'b1, 12'h004, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'hDEADBEEF);

    // byte lanes
    drv_mem(1'b1, 12'h010, 1'b0, 4'b1111, 32'h11223344);
    cycle(1, 1, 32'h0, 32'h0);
    drv_mem(1'b1, 12'h010, 1'b0, 4'b0101, 32'hAABBCCDD);
    cycle(1, 1, 32'h0, 32'h0);
    drv_mem(1'b1, 12'h010, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'h11BB33DD);

    // parallel access to different banks
    drv_if(1'b1, 12'h000, 1'b0, 32'h0BADF00D);
    drv_mem(1'b1, 12'h001, 1'b0, 4'b1111, 32'h12345678);
    cycle(1, 1, 32'h0, 32'h0);
    drv_if(1'b1, 12'h000, 1'b1, 32'h0);
    drv_mem(1'b1, 12'h001, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0BADF00D, 32'h12345678);
    check("parallel_conflict_cnt", {16'b0, spm_conflict_cnt}, 32'd0);

    // conflict and starvation on bank 0
    drv_if(1'b1, 12'h002, 1'b0, 32'h5A5A5A5A);
    drv_mem(1'b0, 12'h000, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'h0);
    drv_if(1'b1, 12'h002, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drv_mem(1'b1, 12'h100 + 12'(2*k), 1'b0, 4'b1111, 32'hC0DE0100 + 32'(2*k));
      cycle(0, 1, 32'h0, 32'h0);
      check("starve_conflict_cnt", {16'b0, spm_conflict_cnt}, 32'(k + 1));
    end
    drv_mem(1'b1, 12'h106, 1'b0, 4'b1111, 32'hC0DE0106);
    cycle(1, 0, 32'h5A5A5A5A, 32'h0);
    check("starve_conflict_cnt4", {16'b0, spm_conflict_cnt}, 32'd4);
    drv_if(1'b0, 12'h000, 1'b1, 32'h0);
    cycle(1, 1, 32'h0, 32'h0);
    check("idle_conflict_cnt4", {16'b0, spm_conflict_cnt}, 32'd4);
    // second episode: IF must lose again, proving the starve count cleared
    drv_if(1'b1, 12'h002, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drv_mem(1'b1, 12'h108 + 12'(2*k), 1'b0, 4'b1111, 32'hC0DE0108 + 32'(2*k));
      cycle(0, 1, 32'h0, 32'h0);
    end
    drv_mem(1'b1, 12'h10E, 1'b0, 4'b1111, 32'hC0DE010E);
    cycle(1, 0, 32'h5A5A5A5A, 32'h0);
    drv_if(1'b0, 12'h000, 1'b1, 32'h0);
    cycle(1, 1, 32'h0, 32'h0);
    check("episode2_conflict_cnt", {16'b0, spm_conflict_cnt}, 32'd8);
    // back-to-back reads of words written while under arbitration
    drv_mem(1'b1, 12'h104, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'hC0DE0104);
    drv_mem(1'b1, 12'h106, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'hC0DE0106);
    drv_mem(1'b1, 12'h10E, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'hC0DE010E);
    drv_mem(1'b0, 12'h000, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'h0);

    // reset mid-operation: accepted MEM read is dropped, IF write ignored
    drv_if(1'b1, 12'h006, 1'b1, 32'h0);
    drv_mem(1'b1, 12'h004, 1'b1, 4'b0000, 32'h0);
    cycle(0, 1, 32'h0, 32'hDEADBEEF);
    reset = 1'b1;
    drv_if(1'b1, 12'h004, 1'b0, 32'hFFFFFFFF);
    drv_mem(1'b0, 12'h000, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'h0);
    reset = 1'b0;
    drv_if(1'b0, 12'h000, 1'b1, 32'h0);
    check("post_reset_conflict_cnt", {16'b0, spm_conflict_cnt}, 32'd0);
    check("post_reset_mem_valid", {31'b0, mem_spm_rd_valid}, 32'd0);
    check("post_reset_mem_data", mem_spm_rd_data, 32'd0);
    drv_mem(1'b1, 12'h004, 1'b1, 4'b0000, 32'h0);
    cycle(1, 1, 32'h0, 32'hDEADBEEF);
    drv_mem(1'b0, 12'h000, 1'b1, 4'b0000, 32'h0);
    drv_if(1'b1, 12'h004, 1'b1, 32'h0);
    cycle(1, 1, 32'hDEADBEEF, 32'h0);

    // saturation: continuous bank-0 write conflicts; starve count starts at 0
    drv_if(1'b1, 12'h202, 1'b0, 32'h01010101);
    drv_mem(1'b1, 12'h200, 1'b0, 4'b1111, 32'h02020202);
    cycle(0, 1, 32'h0, 32'h0);
    cycle(0, 1, 32'h0, 32'h0);
    cycle(0, 1, 32'h0, 32'h0);
    cycle(1, 0, 32'h0, 32'h0);
    check("sat_start_cnt", {16'b0, spm_conflict_cnt}, 32'd4);
    repeat (65530) @(posedge clk);
    #1;
    check("sat_cnt_fffe", {16'b0, spm_conflict_cnt}, 32'h0000FFFE);
    @(posedge clk); #1;
    check("sat_cnt_ffff", {16'b0, spm_conflict_cnt}, 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    check("sat_cnt_hold", {16'b0, spm_conflict_cnt}, 32'h0000FFFF);

    drv_if(1'b0, 12'h000, 1'b1, 32'h0);
    drv_mem(1'b0, 12'h000, 1'b1, 4'b0000, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spm_banked.md
# spm_banked

Parametrised, multi-bank scratchpad memory serving the IF and MEM pipeline stages from one word-interleaved address space. Each bank is single-ported. Requests to different banks complete in the same cycle. Requests to the same bank are arbitrated: MEM has priority, and a starvation counter guarantees IF forward progress. The block replaces the fixed 32-bit, fixed-depth dual-port SPM. It adds byte-lane writes on the MEM port, registered reads with a valid strobe, per-port ready back-pressure, and a saturating conflict counter.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 12, word-address width; total depth 2^ADDR_W words
- NUM_BANKS, 2, bank count; power of two, at least 1, at most 2^ADDR_W
- STARVE_MAX, 3, consecutive IF stall cycles after which IF wins the next conflict
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset; synchronous, active-high
- if_spm_addr  in  ADDR_W  IF word address
- if_spm_as_  in  1  IF address strobe, active-low
- if_spm_rw  in  1  IF read/write: 1 = READ, 0 = WRITE
- if_spm_wr_data  in  DATA_W  IF write data; IF writes are always full-word
- if_spm_rdy  out  1  IF request accepted this cycle (combinational)
- if_spm_rd_data  out  DATA_W  IF read data
- if_spm_rd_valid  out  1  IF read data valid, one-cycle pulse
- mem_spm_addr  in  ADDR_W  MEM word address
- mem_spm_as_  in  1  MEM address strobe, active-low
- mem_spm_rw  in  1  MEM read/write: 1 = READ, 0 = WRITE
- mem_spm_be  in  DATA_W/8  MEM byte-lane write enables; ignored on reads
- mem_spm_wr_data  in  DATA_W  MEM write data
- mem_spm_rdy  out  1  MEM request accepted this cycle (combinational)
- mem_spm_rd_data  out  DATA_W  MEM read data
- mem_spm_rd_valid  out  1  MEM read data valid, one-cycle pulse
- spm_conflict_cnt  out  16  count of same-bank conflicts, saturating

## Operation
- Bank select is addr[log2(NUM_BANKS)-1:0]. Row within the bank is the remaining upper bits. With NUM_BANKS = 1 the bank select is empty and every dual request conflicts.
- A port requests when its as_ is 0. A request is accepted when the port requests and its rdy is 1.
- When a port is not requesting, its rdy is 1.
- No conflict (different banks, or only one requester): both rdy = 1.
- Conflict (both requesting, same bank):
  - starve_cnt < STARVE_MAX: MEM wins; if_spm_rdy = 0, mem_spm_rdy = 1.
  - starve_cnt == STARVE_MAX: IF wins; mem_spm_rdy = 0, if_spm_rdy = 1.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - increments when IF requests and if_spm_rdy = 0;
  - clears when an IF request is accepted;
  - holds otherwise.
- A stalled requester holds addr, rw, data and be stable until rdy = 1. Changing them while stalled is not supported.
- Accepted write: the bank row is updated at the clock edge.
  - MEM writes only the lanes where mem_spm_be[i] = 1.
  - IF writes all lanes.
- Accepted read: data appears on rd_data in the next cycle, with rd_valid = 1 for exactly that cycle.
- rd_data holds its last value while rd_valid = 0.
- A read in any cycle after a write observes the written data. A same-cycle read and write to one bank cannot occur, because it is a conflict and is serialised.
- spm_conflict_cnt increments by 1 on every conflict cycle and saturates at 16'hFFFF.
- Memory contents are not initialised or cleared by reset.

## Timing
- Read latency: 1 cycle from acceptance to rd_valid.
- Fully pipelined: back-to-back accepted reads give rd_valid on consecutive cycles.
- rdy depends combinationally on as_, addr and starve_cnt. It has no dependency on rd_* outputs.
- Reset values:
  - if_spm_rd_valid = 0, mem_spm_rd_valid = 0
  - if_spm_rd_data = 0, mem_spm_rd_data = 0
  - starve_cnt = 0, spm_conflict_cnt = 0
- While reset = 1, no write is performed, even if a request is present.
- Reset asserted the cycle after a read was accepted: rd_valid stays 0 and that read is dropped.

## Test plan
- Basic MEM write/read: MEM write addr 0x004, be = 4'b1111, data 0xDEADBEEF; MEM read 0x004 next cycle -> one cycle later mem_spm_rd_data = 0xDEADBEEF, mem_spm_rd_valid pulses for 1 cycle.
- Byte lanes: preload 0x11223344 at 0x010; MEM write be = 4'b0101, data 0xAABBCCDD; read back -> 0x11BB33DD.
- Parallel access: NUM_BANKS = 2; IF reads 0x000 while MEM reads 0x001 in the same cycle -> both rdy = 1, both rd_valid pulse next cycle, spm_conflict_cnt unchanged.
- Conflict and starvation: STARVE_MAX = 3; IF and MEM both continuously request bank 0 (IF 0x002, MEM new even addresses each cycle) -> if_spm_rdy = 0 for 3 cycles, then IF accepted on the 4th with mem_spm_rdy = 0 that cycle; starve_cnt returns to 0; spm_conflict_cnt = 4.
- Reset mid-operation: accept a MEM read, assert reset the next cycle -> mem_spm_rd_valid = 0, rd_data = 0, counters = 0. An IF write presented during reset does not change memory, verified by a read after reset deasserts.
- Saturation: force 65 540 conflict cycles -> spm_conflict_cnt = 0xFFFF and it stays there.
